// File: rtl/mem_clr_ram_if.sv
// Access bus for mem_clr_ram: clear request, request/ready handshake, read data and error pulses.
interface mem_clr_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              clr;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              ready;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              err;

    modport master (
        output clr, req, we, addr, din,
        input  ready, dout, dout_valid, err
    );

    modport slave (
        input  clr, req, we, addr, din,
        output ready, dout, dout_valid, err
    );
endinterface

// File: rtl/mem_clr_ram.sv
// Single-port RAM that self-zeroes for DEPTH cycles after reset or clr; reads have 1-cycle latency.
// ready drops during zeroing and in the clr cycle; requests seen while not ready are dropped, never queued.
module mem_clr_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic          clk,
    input  logic          rst,
    mem_clr_ram_if.slave  bus
);
    localparam int                CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_err;

    logic              w_ready;
    logic              w_acc;
    logic              w_in_range;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdat;

    assign w_ready    = (r_state == ST_RUN) && !bus.clr;
    assign w_acc      = bus.req && w_ready;
    assign w_in_range = ({1'b0, bus.addr} < DEPTH_A);

    // One write port shared between the zeroing sweep and accepted in-range writes.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = bus.addr;
        w_mem_wdat = bus.din;
        if (r_state == ST_INIT) begin
            w_mem_we   = !rst;
            w_mem_addr = ADDR_W'(r_cnt);
            w_mem_wdat = '0;
        end else if (w_acc && bus.we && w_in_range) begin
            w_mem_we   = !rst;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    if (bus.clr) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.clr) begin
                        r_state <= ST_INIT;
                        r_cnt   <= '0;
                    end else if (bus.req) begin
                        if (!bus.we) begin
                            r_dout_valid <= 1'b1;
                            r_dout       <= w_in_range ? r_mem[bus.addr] : '0;
                        end
                        r_err <= !w_in_range;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.ready      = w_ready;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_mem_clr_ram.sv
// Bench for mem_clr_ram: default-size instance plus a DEPTH=200 instance for out-of-range cases.
module tb_mem_clr_ram;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_clr_ram_if #(.DATA_W(8), .ADDR_W(8)) bus  ();
    mem_clr_ram_if #(.DATA_W(8), .ADDR_W(8)) bus2 ();

    mem_clr_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut    (.clk(clk), .rst(rst), .bus(bus));
    mem_clr_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) dut200 (.clk(clk), .rst(rst), .bus(bus2));

    int checks = 0;
    int errors = 0;

    // Reference model of the default instance: array contents plus expected outputs for the next cycle.
    logic [7:0] mdl [256];
    logic [7:0] exp_dout;
    logic       exp_vld;
    logic       exp_err;

    task automatic drv(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        bus.req = r; bus.we = w; bus.addr = a; bus.din = d;
    endtask

    task automatic drv2(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        bus2.req = r; bus2.we = w; bus2.addr = a; bus2.din = d;
    endtask

    task automatic model_acc(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        exp_vld = 1'b0;
        exp_err = 1'b0;
        if (r) begin
            if (w) mdl[a] = d;
            else begin
                exp_vld  = 1'b1;
                exp_dout = mdl[a];
            end
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    endtask

    task automatic test_reset();
        int n;
        int n2;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", bus.ready); end
        checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h want=00", bus.dout); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b want=0", bus.dout_valid); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", bus.err); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n = 0; n2 = 0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (bus2.ready === 1'b1 && n2 == 0) n2 = k;
            if (bus.ready === 1'b1) begin n = k; break; end
        end
        checks++; if (n != 256) begin errors++; $display("FAIL reset_init_len got=%0d want=256", n); end
        checks++; if (n2 != 200) begin errors++; $display("FAIL reset_init_len200 got=%0d want=200", n2); end
        model_zero();
        for (int i = 0; i <= 256; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b1)
                    begin errors++; $display("FAIL zero_read a=%0d got=%h/%b want=00/1", i - 1, bus.dout, bus.dout_valid); end
            end
            if (i > 0 && i <= 200) begin
                checks++; if (bus2.dout !== 8'h00 || bus2.dout_valid !== 1'b1 || bus2.err !== 1'b0)
                    begin errors++; $display("FAIL zero_read200 a=%0d got=%h/%b/%b want=00/1/0", i - 1, bus2.dout, bus2.dout_valid, bus2.err); end
            end
            if (i < 256) drv(1'b1, 1'b0, 8'(i), 8'h00); else drv(1'b0, 1'b0, 8'h00, 8'h00);
            if (i < 200) drv2(1'b1, 1'b0, 8'(i), 8'h00); else drv2(1'b0, 1'b0, 8'h00, 8'h00);
        end
        exp_dout = 8'h00; exp_vld = 1'b0; exp_err = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        drv(1'b1, 1'b1, 8'h10, 8'hA5); model_acc(1'b1, 1'b1, 8'h10, 8'hA5);
        @(negedge clk);
        checks++; if (bus.dout_valid !== 1'b0 || bus.err !== 1'b0)
            begin errors++; $display("FAIL wr_no_pulse got=%b/%b want=0/0", bus.dout_valid, bus.err); end
        drv(1'b1, 1'b0, 8'h10, 8'h00); model_acc(1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        checks++; if (bus.dout !== 8'hA5) begin errors++; $display("FAIL raw_dout got=%h want=a5", bus.dout); end
        checks++; if (bus.dout_valid !== 1'b1 || bus.err !== 1'b0)
            begin errors++; $display("FAIL raw_flags got=%b/%b want=1/0", bus.dout_valid, bus.err); end
        drv(1'b0, 1'b0, 8'h00, 8'h00); model_acc(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        checks++; if (bus.dout_valid !== 1'b0 || bus.dout !== 8'hA5)
            begin errors++; $display("FAIL raw_one_cycle got=%b/%h want=0/a5", bus.dout_valid, bus.dout); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drv(1'b1, 1'b1, 8'(i), 8'(i + 1)); model_acc(1'b1, 1'b1, 8'(i), 8'(i + 1));
        end
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (bus.dout !== 8'(i) || bus.dout_valid !== 1'b1)
                    begin errors++; $display("FAIL b2b_read%0d got=%h/%b want=%h/1", i - 1, bus.dout, bus.dout_valid, 8'(i)); end
            end
            if (i < 4) begin drv(1'b1, 1'b0, 8'(i), 8'h00); model_acc(1'b1, 1'b0, 8'(i), 8'h00); end
            else begin drv(1'b0, 1'b0, 8'h00, 8'h00); model_acc(1'b0, 1'b0, 8'h00, 8'h00); end
        end
        @(negedge clk);
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_vld got=%b want=0", bus.dout_valid); end
    endtask

    task automatic test_oor();
        @(negedge clk); drv2(1'b1, 1'b1, 8'h01, 8'h11);
        @(negedge clk); drv2(1'b1, 1'b1, 8'hC7, 8'h66);
        @(negedge clk); drv2(1'b1, 1'b0, 8'h01, 8'h00);
        @(negedge clk);
        checks++; if (bus2.dout !== 8'h11 || bus2.dout_valid !== 1'b1 || bus2.err !== 1'b0)
            begin errors++; $display("FAIL oor_pre got=%h/%b/%b want=11/1/0", bus2.dout, bus2.dout_valid, bus2.err); end
        drv2(1'b1, 1'b0, 8'hF0, 8'h00);
        @(negedge clk);
        checks++; if (bus2.dout !== 8'h00 || bus2.dout_valid !== 1'b1 || bus2.err !== 1'b1)
            begin errors++; $display("FAIL oor_read got=%h/%b/%b want=00/1/1", bus2.dout, bus2.dout_valid, bus2.err); end
        drv2(1'b1, 1'b1, 8'hF0, 8'h55);
        @(negedge clk);
        checks++; if (bus2.dout !== 8'h00 || bus2.dout_valid !== 1'b0 || bus2.err !== 1'b1)
            begin errors++; $display("FAIL oor_write got=%h/%b/%b want=00/0/1", bus2.dout, bus2.dout_valid, bus2.err); end
        drv2(1'b1, 1'b0, 8'h28, 8'h00);
        @(negedge clk);
        checks++; if (bus2.dout !== 8'h00 || bus2.dout_valid !== 1'b1 || bus2.err !== 1'b0)
            begin errors++; $display("FAIL oor_alias got=%h/%b/%b want=00/1/0", bus2.dout, bus2.dout_valid, bus2.err); end
        drv2(1'b1, 1'b0, 8'hC8, 8'h00);
        @(negedge clk);
        checks++; if (bus2.dout !== 8'h00 || bus2.err !== 1'b1)
            begin errors++; $display("FAIL oor_edge200 got=%h/%b want=00/1", bus2.dout, bus2.err); end
        drv2(1'b1, 1'b0, 8'hC7, 8'h00);
        @(negedge clk);
        checks++; if (bus2.dout !== 8'h66 || bus2.dout_valid !== 1'b1 || bus2.err !== 1'b0)
            begin errors++; $display("FAIL oor_last got=%h/%b/%b want=66/1/0", bus2.dout, bus2.dout_valid, bus2.err); end
        drv2(1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        checks++; if (bus2.dout_valid !== 1'b0 || bus2.err !== 1'b0)
            begin errors++; $display("FAIL oor_idle got=%b/%b want=0/0", bus2.dout_valid, bus2.err); end
    endtask

    task automatic test_random();
        logic       r, w;
        logic [7:0] a, d;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            checks++; if (bus.dout !== exp_dout) begin errors++; $display("FAIL rnd_dout cyc=%0d got=%h want=%h", cyc, bus.dout, exp_dout); end
            checks++; if (bus.dout_valid !== exp_vld) begin errors++; $display("FAIL rnd_vld cyc=%0d got=%b want=%b", cyc, bus.dout_valid, exp_vld); end
            checks++; if (bus.err !== exp_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b want=%b", cyc, bus.err, exp_err); end
            r = ($urandom_range(0, 3) != 0);
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            drv(r, w, a, d); model_acc(r, w, a, d);
        end
        @(negedge clk);
        checks++; if (bus.dout !== exp_dout || bus.dout_valid !== exp_vld)
            begin errors++; $display("FAIL rnd_last got=%h/%b want=%h/%b", bus.dout, bus.dout_valid, exp_dout, exp_vld); end
        drv(1'b0, 1'b0, 8'h00, 8'h00); model_acc(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_clr();
        int n;
        int viol;
        @(negedge clk); drv(1'b1, 1'b1, 8'h05, 8'h3C); model_acc(1'b1, 1'b1, 8'h05, 8'h3C);
        @(negedge clk); drv(1'b1, 1'b0, 8'h05, 8'h00); model_acc(1'b1, 1'b0, 8'h05, 8'h00);
        @(negedge clk);
        checks++; if (bus.dout !== 8'h3C || bus.dout_valid !== 1'b1)
            begin errors++; $display("FAIL clr_pre got=%h/%b want=3c/1", bus.dout, bus.dout_valid); end
        drv(1'b0, 1'b0, 8'h00, 8'h00);
        bus.clr = 1'b1;
        #1;
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL clr_ready got=%b want=0", bus.ready); end
        @(negedge clk);
        bus.clr = 1'b0;
        model_zero();
        n = 0; viol = 0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (bus.dout_valid !== 1'b0) viol++;
            if (bus.ready === 1'b1) begin n = k; break; end
            if (k == 10) drv(1'b1, 1'b0, 8'h05, 8'h00);
            if (k == 12) drv(1'b0, 1'b0, 8'h00, 8'h00);
        end
        checks++; if (n != 256) begin errors++; $display("FAIL clr_init_len got=%0d want=256", n); end
        checks++; if (viol != 0) begin errors++; $display("FAIL clr_req_ignored got=%0d want=0", viol); end
        @(negedge clk);
        checks++; if (bus.dout !== 8'h3C || bus.dout_valid !== 1'b0)
            begin errors++; $display("FAIL clr_dout_hold got=%h/%b want=3c/0", bus.dout, bus.dout_valid); end
        drv(1'b1, 1'b0, 8'h05, 8'h00); model_acc(1'b1, 1'b0, 8'h05, 8'h00);
        @(negedge clk);
        checks++; if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b1)
            begin errors++; $display("FAIL clr_zeroed got=%h/%b want=00/1", bus.dout, bus.dout_valid); end
        drv(1'b0, 1'b0, 8'h00, 8'h00); model_acc(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_async_rst();
        int n;
        int viol;
        @(negedge clk); drv(1'b1, 1'b1, 8'h20, 8'h9E); model_acc(1'b1, 1'b1, 8'h20, 8'h9E);
        @(negedge clk); drv(1'b1, 1'b0, 8'h20, 8'h00); model_acc(1'b1, 1'b0, 8'h20, 8'h00);
        @(posedge clk); #1;
        checks++; if (bus.dout !== 8'h9E || bus.dout_valid !== 1'b1)
            begin errors++; $display("FAIL arst_pre got=%h/%b want=9e/1", bus.dout, bus.dout_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.ready !== 1'b0 || bus.dout !== 8'h00 || bus.dout_valid !== 1'b0 || bus.err !== 1'b0)
            begin errors++; $display("FAIL arst_now got=%b/%h/%b/%b want=0/00/0/0", bus.ready, bus.dout, bus.dout_valid, bus.err); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL arst_hold_vld got=%b want=0", bus.dout_valid); end
        drv(1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        model_zero();
        n = 0; viol = 0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (bus.dout_valid !== 1'b0) viol++;
            if (bus.ready === 1'b1) begin n = k; break; end
        end
        checks++; if (n != 256) begin errors++; $display("FAIL arst_init_len got=%0d want=256", n); end
        checks++; if (viol != 0) begin errors++; $display("FAIL arst_stray_vld got=%0d want=0", viol); end
        exp_dout = 8'h00;
        @(negedge clk); drv(1'b1, 1'b0, 8'h20, 8'h00); model_acc(1'b1, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        checks++; if (bus.dout !== exp_dout || bus.dout_valid !== 1'b1)
            begin errors++; $display("FAIL arst_zeroed got=%h/%b want=%h/1", bus.dout, bus.dout_valid, exp_dout); end
        drv(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        bus.clr = 1'b0;  drv(1'b0, 1'b0, 8'h00, 8'h00);
        bus2.clr = 1'b0; drv2(1'b0, 1'b0, 8'h00, 8'h00);
        exp_dout = 8'h00; exp_vld = 1'b0; exp_err = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_oor();
        test_random();
        test_clr();
        test_async_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_clr_ram.md
MEM_CLR_RAM -- requirements
Module: mem_clr_ram

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width in bits.
REQ-003 Parameter DEPTH, default 256, number of words; legal range 2..2^ADDR_W.
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset; asynchronous and active-high.
REQ-006 Port clr  input  1  synchronous request to re-zero the whole array.
REQ-007 Port req  input  1  access request, qualified by ready.
REQ-008 Port we  input  1  1 = write, 0 = read; sampled with req.
REQ-009 Port addr  input  ADDR_W  word address; sampled with req.
REQ-010 Port din  input  DATA_W  write data; sampled with req.
REQ-011 Port ready  output  1  block accepts req this cycle.
REQ-012 Port dout  output  DATA_W  registered read data.
REQ-013 Port dout_valid  output  1  one-cycle pulse: dout updated by a read.
REQ-014 Port err  output  1  one-cycle pulse: accepted access had addr >= DEPTH.

Function
REQ-015 FSM has two states, INIT and RUN; ready = 1 exactly when state is RUN and clr = 0.
REQ-016 INIT: each rising edge writes 0 to mem[cnt] and increments cnt, a clog2(DEPTH)-bit counter.
REQ-017 INIT exit: the edge that writes address DEPTH-1 moves the FSM to RUN and clears cnt; INIT lasts exactly DEPTH cycles.
REQ-018 RUN with clr = 1: next edge enters INIT with cnt = 0; no access is accepted that cycle.
REQ-019 INIT with clr = 1: cnt restarts at 0.
REQ-020 Accepted access: req = 1 and ready = 1 at a rising edge; req is ignored while ready = 0, with no queueing.
REQ-021 Accepted write with addr < DEPTH: mem[addr] = din at that edge; dout and dout_valid are unchanged.
REQ-022 Accepted read with addr < DEPTH: dout = mem[addr] at that edge; dout_valid = 1 for the following cycle; latency is 1 cycle.
REQ-023 Back-to-back reads on consecutive cycles are supported; dout_valid stays high continuously, with one valid word per cycle.
REQ-024 A read one cycle after a write to the same address returns the newly written data.
REQ-025 dout holds its last value between reads, across clr, and across INIT.
REQ-026 Out-of-range accepted write (addr >= DEPTH): memory is unchanged; err = 1 for one cycle.
REQ-027 Out-of-range accepted read: dout = 0, dout_valid = 1 and err = 1, all in the same following cycle.
REQ-028 Outside the pulses above, dout_valid = 0 and err = 0.
REQ-029 Memory contents are retained across clr only until INIT overwrites them.

Reset
REQ-030 rst = 1 immediately, without waiting for clk, forces: state = INIT, cnt = 0, ready = 0, dout = 0, dout_valid = 0, err = 0.
REQ-031 Memory array contents are not reset directly; INIT zeroes them after rst deasserts.
REQ-032 rst asserted mid-INIT or mid-access aborts the operation; any read pending at that moment produces no dout_valid.
REQ-033 The first edge after rst deasserts writes address 0; ready rises after DEPTH edges.

Verification
REQ-034 Defaults; rst pulse, then count edges -> ready = 0 for 256 edges, ready = 1 after edge 256; read of every address returns 0x00.
REQ-035 Write 0xA5 to 0x10, then read 0x10 on the next cycle -> one cycle later dout = 0xA5, dout_valid = 1 for exactly one cycle, err = 0.
REQ-036 DEPTH = 200; read at addr 0xF0 -> dout = 0x00, dout_valid = 1, err = 1; write 0x55 to 0xF0 -> err pulse only, and a read of 0xF0 - 200 = 0x28 is still 0x00.
REQ-037 Write 0x3C to 0x05, pulse clr for one cycle -> ready = 0 for 256 cycles; a req during INIT is ignored; read of 0x05 afterwards returns 0x00.
REQ-038 Four reads on consecutive cycles at 0..3, preloaded with 1..4 -> dout = 1, 2, 3, 4 on consecutive cycles with dout_valid held high for 4 cycles.
REQ-039 Assert rst asynchronously between edges during a read -> ready, dout and dout_valid go to 0 before the next edge, and INIT restarts from address 0.
